// File: rtl/tim_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tim_pkg : shared types and constants for the timer controller      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package tim_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tim_state_e;

endpackage : tim_pkg
`default_nettype wire

// File: rtl/tim_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tim_prescaler : divides clk by (psc+1), emitting a one-cycle tick   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tim_prescaler
  import tim_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] psc_i,
  output logic             tick_o
);

  logic [CNT_W-1:0] psc_cnt_q;
  logic [CNT_W-1:0] psc_cnt_d;

  assign tick_o = en_i && (psc_cnt_q == psc_i);

  always_comb begin
    psc_cnt_d = psc_cnt_q;
    if (clr_i) begin
      psc_cnt_d = '0;
    end else if (en_i) begin
      psc_cnt_d = tick_o ? '0 : psc_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc_cnt_q <= '0;
    end else begin
      psc_cnt_q <= psc_cnt_d;
    end
  end

endmodule : tim_prescaler
`default_nettype wire

// File: rtl/tim_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tim_ctrl : up-counting timer with preloaded PSC/ARR and update IRQ  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tim_ctrl
  import tim_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] tim_psc,
  input  logic [CNT_W-1:0] tim_arr,
  input  logic             cfg_wr,
  input  logic             start,
  input  logic             stop,
  input  logic             one_pulse,
  input  logic             irq_ack,
  output logic [CNT_W-1:0] cnt,
  output logic             update_evt,
  output logic             irq,
  output logic             busy
);

  tim_state_e       state_q, state_d;
  logic [CNT_W-1:0] psc_pre_q, psc_pre_d;
  logic [CNT_W-1:0] arr_pre_q, arr_pre_d;
  logic [CNT_W-1:0] psc_act_q, psc_act_d;
  logic [CNT_W-1:0] arr_act_q, arr_act_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             upd_q, upd_d;
  logic             irq_q, irq_d;
  logic             psc_clr;
  logic             tick;

  tim_prescaler #(
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .en_i   (state_q == RUN),
    .clr_i  (psc_clr),
    .psc_i  (psc_act_q),
    .tick_o (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    psc_pre_d = psc_pre_q;
    arr_pre_d = arr_pre_q;
    psc_act_d = psc_act_q;
    arr_act_d = arr_act_q;
    cnt_d     = cnt_q;
    upd_d     = 1'b0;
    irq_d     = irq_q & ~irq_ack;
    psc_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_wr) begin
          psc_pre_d = tim_psc;
          arr_pre_d = tim_arr;
          psc_act_d = tim_psc;
          arr_act_d = tim_arr;
        end
        if (start && !stop) begin
          state_d = RUN;
          cnt_d   = '0;
          psc_clr = 1'b1;
        end
      end
      RUN: begin
        if (cfg_wr) begin
          psc_pre_d = tim_psc;
          arr_pre_d = tim_arr;
        end
        // stop wins over a coincident wrap: nothing of the update is applied
        if (stop) begin
          state_d = IDLE;
          psc_clr = 1'b1;
        end else if (tick) begin
          if (cnt_q == arr_act_q) begin
            cnt_d     = '0;
            upd_d     = 1'b1;
            irq_d     = 1'b1;
            psc_act_d = cfg_wr ? tim_psc : psc_pre_q;
            arr_act_d = cfg_wr ? tim_arr : arr_pre_q;
            if (one_pulse) begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc_pre_q <= '0;
      arr_pre_q <= '0;
      psc_act_q <= '0;
      arr_act_q <= '0;
      cnt_q     <= '0;
      upd_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      psc_pre_q <= psc_pre_d;
      arr_pre_q <= arr_pre_d;
      psc_act_q <= psc_act_d;
      arr_act_q <= arr_act_d;
      cnt_q     <= cnt_d;
      upd_q     <= upd_d;
      irq_q     <= irq_d;
    end
  end

  assign cnt        = cnt_q;
  assign update_evt = upd_q;
  assign irq        = irq_q;
  assign busy       = (state_q == RUN);

endmodule : tim_ctrl
`default_nettype wire

// File: tb/tb_tim_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_tim_ctrl : directed scoreboard bench for tim_ctrl               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_tim_ctrl;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         upd;
    logic         irq;
    logic         busy;
  } obs_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] tim_psc = '0;
  logic [W-1:0] tim_arr = '0;
  logic         cfg_wr = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         one_pulse = 1'b0;
  logic         irq_ack = 1'b0;
  logic [W-1:0] cnt;
  logic         update_evt;
  logic         irq;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;
  obs_t sb[$];

  // reference model state
  logic         m_run;
  logic [W-1:0] m_pp, m_ap, m_pa, m_aa, m_pc, m_cnt;
  logic         m_upd, m_irq;

  tim_ctrl #(.CNT_W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .tim_psc    (tim_psc),
    .tim_arr    (tim_arr),
    .cfg_wr     (cfg_wr),
    .start      (start),
    .stop       (stop),
    .one_pulse  (one_pulse),
    .irq_ack    (irq_ack),
    .cnt        (cnt),
    .update_evt (update_evt),
    .irq        (irq),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_run = 1'b0; m_pp = '0; m_ap = '0; m_pa = '0; m_aa = '0;
    m_pc = '0; m_cnt = '0; m_upd = 1'b0; m_irq = 1'b0;
  endtask

  task automatic model_step(input logic c, input logic [W-1:0] p, input logic [W-1:0] a,
                            input logic s, input logic sp, input logic op, input logic ak);
    logic u;
    u = 1'b0;
    if (!m_run) begin
      if (c) begin m_pp = p; m_ap = a; m_pa = p; m_aa = a; end
      if (s && !sp) begin m_run = 1'b1; m_cnt = '0; m_pc = '0; end
    end else begin
      if (c) begin m_pp = p; m_ap = a; end
      if (sp) begin
        m_run = 1'b0; m_pc = '0;
      end else if (m_pc != m_pa) begin
        m_pc = m_pc + 1;
      end else begin
        m_pc = '0;
        if (m_cnt != m_aa) begin
          m_cnt = m_cnt + 1;
        end else begin
          m_cnt = '0; u = 1'b1; m_pa = m_pp; m_aa = m_ap;
          if (op) m_run = 1'b0;
        end
      end
    end
    m_irq = u | (m_irq & ~ak);
    m_upd = u;
  endtask

  function automatic logic wrap_next();
    return m_run && (m_pc == m_pa) && (m_cnt == m_aa);
  endfunction

  task automatic check(input string tag, input obs_t o, input obs_t e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed cnt=%0d upd=%b irq=%b busy=%b expected cnt=%0d upd=%b irq=%b busy=%b",
             tag, o.cnt, o.upd, o.irq, o.busy, e.cnt, e.upd, e.irq, e.busy);
    end
  endtask

  task automatic step(input string tag, input logic c, input logic [W-1:0] p, input logic [W-1:0] a,
                      input logic s, input logic sp, input logic op, input logic ak);
    obs_t e, o;
    cfg_wr = c; tim_psc = p; tim_arr = a; start = s; stop = sp; one_pulse = op; irq_ack = ak;
    model_step(c, p, a, s, sp, op, ak);
    sb.push_back({m_cnt, m_upd, m_irq, m_run});
    @(posedge clk); #1;
    e = sb.pop_front();
    o = {cnt, update_evt, irq, busy};
    check(tag, o, e);
    cfg_wr = 1'b0; start = 1'b0; stop = 1'b0; irq_ack = 1'b0;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, tim_psc, tim_arr, 1'b0, 1'b0, one_pulse, 1'b0);
  endtask

  task automatic run_to_cnt(input string tag, input logic [W-1:0] target);
    int guard;
    guard = 0;
    while (m_cnt != target && guard < 200) begin
      idle(tag, 1);
      guard++;
    end
    n_vec++;
    assert (guard < 200) else begin
      n_err++;
      $error("FAIL %s_timeout observed guard=%0d expected below 200", tag, guard);
    end
  endtask

  initial begin
    obs_t o;
    int   pulses;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {cnt, update_evt, irq, busy}, '0);
    reset = 1'b0;
    idle("idle_after_reset", 2);

    // psc=0 arr=3: wrap every 4 cycles
    step("cfg_036", 1'b1, 16'd0, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step("start_036", 1'b0, 16'd0, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      idle("run_036", 1);
      if (update_evt) pulses++;
    end
    n_vec++;
    assert (pulses == 3) else begin
      n_err++;
      $error("FAIL pulses_036 observed %0d expected 3", pulses);
    end
    step("ack_plain", 1'b0, 16'd0, 16'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    // ack coinciding with the update edge leaves irq set
    for (int i = 0; i < 8; i++)
      step("ack_vs_update", 1'b0, 16'd0, 16'd3, 1'b0, 1'b0, 1'b0, wrap_next());
    step("start_in_run", 1'b0, 16'd0, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    idle("after_start_in_run", 3);
    step("stop_036", 1'b0, 16'd0, 16'd3, 1'b0, 1'b1, 1'b0, 1'b0);

    // psc=2 arr=1: cnt moves every 3 cycles, update every 6
    step("cfg_037", 1'b1, 16'd2, 16'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    step("start_037", 1'b0, 16'd2, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle("run_037", 14);
    step("stop_037", 1'b0, 16'd2, 16'd1, 1'b0, 1'b1, 1'b0, 1'b0);

    // preload: mid-period ARR change takes effect after the next wrap
    step("cfg_038", 1'b1, 16'd0, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step("start_038", 1'b0, 16'd0, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    idle("run_038a", 1);
    step("cfg_mid_038", 1'b1, 16'd0, 16'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("run_038b", 14);

    // stop at cnt=2 holds the count
    run_to_cnt("seek_cnt2", 16'd2);
    step("stop_at_2", 1'b0, 16'd0, 16'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    check("stop_holds", {cnt, update_evt, irq, busy}, {16'd2, 1'b0, m_irq, 1'b0});
    idle("idle_hold", 3);
    step("start_stop", 1'b0, 16'd0, 16'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    n_vec++;
    assert (busy === 1'b0) else begin
      n_err++;
      $error("FAIL start_stop_busy observed %b expected 0", busy);
    end

    // arr=0: every tick is an update, cnt stays 0
    step("cfg_arr0", 1'b1, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("start_arr0", 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle("run_arr0", 4);
    step("stop_arr0", 1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1);

    // one-pulse mode
    step("cfg_039", 1'b1, 16'd0, 16'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    step("start_039", 1'b0, 16'd0, 16'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step("run_039", 1'b0, 16'd0, 16'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      if (update_evt) pulses++;
    end
    n_vec++;
    assert (pulses == 1) else begin
      n_err++;
      $error("FAIL pulses_039 observed %0d expected 1", pulses);
    end
    one_pulse = 1'b0;

    // asynchronous reset mid-run
    step("cfg_041", 1'b1, 16'd0, 16'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    step("start_041", 1'b0, 16'd0, 16'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    run_to_cnt("seek_cnt5", 16'd5);
    #2 reset = 1'b1;
    #1;
    check("async_reset", {cnt, update_evt, irq, busy}, '0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    idle("after_reset", 12);
    o = {cnt, update_evt, irq, busy};
    check("post_reset_quiet", o, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_tim_ctrl
`default_nettype wire

// File: doc/tim_ctrl.md
TIM_CTRL -- requirements
Module: tim_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of prescaler, auto-reload and counter values.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 tim_psc  input  CNT_W  prescaler value from datapath TIM_PSC register.
REQ-005 tim_arr  input  CNT_W  auto-reload value from datapath TIM_ARR register.
REQ-006 cfg_wr  input  1  one-cycle strobe; capture tim_psc/tim_arr.
REQ-007 start  input  1  one-cycle strobe; begin counting.
REQ-008 stop  input  1  one-cycle strobe; halt counting.
REQ-009 one_pulse  input  1  level; 1 = stop automatically after first update event.
REQ-010 irq_ack  input  1  one-cycle strobe; clear irq.
REQ-011 cnt  output  CNT_W  current counter value.
REQ-012 update_evt  output  1  registered one-cycle pulse per counter wrap.
REQ-013 irq  output  1  sticky update interrupt flag.
REQ-014 busy  output  1  high while in RUN.

Function
REQ-015 FSM states: IDLE, RUN; busy = (state == RUN).
REQ-016 Registers: psc_pre/arr_pre (preload), psc_act/arr_act (active), psc_cnt, cnt.
REQ-017 cfg_wr in IDLE: tim_psc/tim_arr written to both preload and active registers.
REQ-018 cfg_wr in RUN: written to preload only; active registers take preload value at the next update event.
REQ-019 cfg_wr coinciding with an update event: new tim_psc/tim_arr bypass to active registers at that same edge.
REQ-020 IDLE + start: go to RUN, psc_cnt <= 0, cnt <= 0; cfg_wr in the same cycle applies first (REQ-017).
REQ-021 RUN: psc_cnt increments each cycle; at psc_cnt == psc_act, psc_cnt <= 0 and a tick is generated; counter advances every psc_act+1 cycles.
REQ-022 On tick: cnt increments; if cnt == arr_act, cnt <= 0 and update_evt is asserted for the following cycle only.
REQ-023 arr_act == 0: every tick is an update event; cnt stays 0.
REQ-024 psc_act == 0: a tick occurs every RUN cycle.
REQ-025 Counter wrap is at arr_act only; no unsigned overflow path exists (the all-ones ARR value wraps to 0).
REQ-026 start while in RUN: ignored, no counter restart.
REQ-027 stop: go to IDLE; cnt holds its value; psc_cnt <= 0; a pending update at the same edge is suppressed.
REQ-028 stop and start in the same cycle: stop wins.
REQ-029 one_pulse == 1 at an update edge: go to IDLE, cnt <= 0; update_evt and irq still fire.
REQ-030 irq set at each update event; cleared by irq_ack; simultaneous set and ack leaves irq = 1.
REQ-031 cnt, psc_cnt and registers are unchanged in IDLE except via cfg_wr/start.

Reset
REQ-032 reset asserted: state = IDLE; all preload, active and counter registers = 0; cnt = 0, update_evt = 0, irq = 0, busy = 0, taking effect immediately without waiting for clk.
REQ-033 reset mid-RUN: counting aborts; all configuration is lost; after release, a cfg_wr is required before meaningful operation.

Structure
REQ-034 Package tim_pkg holds the state enum (IDLE, RUN) and the CNT_W default constant.
REQ-035 One sub-module, tim_prescaler, holds psc_cnt and emits tick; the FSM, counter, preload and irq logic stay in tim_ctrl.

Verification
REQ-036 cfg_wr psc=0, arr=3, then start -> cnt 0,1,2,3,0...; update_evt pulses every 4 cycles, first on the 4th cycle after start; irq = 1.
REQ-037 psc=2, arr=1, start -> cnt changes every 3 cycles; update_evt period 6 cycles.
REQ-038 In RUN with arr=3, cfg_wr arr=7 mid-period -> current period still wraps at 3; the next period wraps at 7.
REQ-039 one_pulse=1, psc=0, arr=2, start -> one update_evt, then busy=0, cnt=0; no further pulses.
REQ-040 start+stop same cycle -> stays IDLE. stop at cnt=2 -> cnt holds 2, busy=0. irq_ack in the same cycle as update -> irq remains 1.
REQ-041 Assert reset during RUN at cnt=5 -> all outputs 0 immediately; no update_evt after release until cfg_wr and start.
